// File: rtl/famicom_input_arbiter_if.sv
// Joystick, keyboard-queue and Famicom serial-port signals between the
// input sources, the arbiter and the Gigatron controller pins.
interface famicom_input_arbiter_if #(
   parameter int FIFO_DEPTH = 4
) ();
   logic [7:0]                    joystick;
   logic                          key_strobe;
   logic [7:0]                    key_ascii;
   logic                          famicom_latch;
   logic                          famicom_pulse;
   logic                          famicom_data;
   logic [$clog2(FIFO_DEPTH):0]   fifo_count;
   logic                          overflow;
   logic                          busy;

   modport master (
      output joystick, key_strobe, key_ascii, famicom_latch, famicom_pulse,
      input  famicom_data, fifo_count, overflow, busy
   );

   modport slave (
      input  joystick, key_strobe, key_ascii, famicom_latch, famicom_pulse,
      output famicom_data, fifo_count, overflow, busy
   );
endinterface

// File: rtl/famicom_input_arbiter.sv
// Famicom controller-port emulation shared between the MiSTer joystick and
// queued ASCII keystrokes; latch/pulse are synchronized into clk_sys.
module famicom_input_arbiter #(
   parameter int FIFO_DEPTH  = 4,
   parameter int HOLD_FRAMES = 3,
   parameter int GAP_FRAMES  = 2
) (
   input  logic                    clk_sys,
   input  logic                    reset,
   famicom_input_arbiter_if.slave  bus
);
   localparam int AW   = $clog2(FIFO_DEPTH);
   localparam int CW   = AW + 1;
   localparam int MAXF = (HOLD_FRAMES > GAP_FRAMES) ? HOLD_FRAMES : GAP_FRAMES;
   localparam int NW   = (MAXF < 2) ? 1 : $clog2(MAXF);
   localparam logic [NW-1:0] HOLD_LAST = NW'(HOLD_FRAMES - 1);
   localparam logic [NW-1:0] GAP_LAST  = NW'(GAP_FRAMES - 1);
   localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_GAP} state_t;

   logic latch_s1_q, latch_s2_q, latch_h_q, latch_s1_d, latch_s2_d, latch_h_d;
   logic pulse_s1_q, pulse_s2_q, pulse_h_q, pulse_s1_d, pulse_s2_d, pulse_h_d;
   logic [7:0]    sr_q, sr_d;
   logic [7:0]    cur_q, cur_d;
   logic [NW-1:0] cnt_q, cnt_d;
   state_t        state_q, state_d;
   logic [CW-1:0] count_q, count_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic          overflow_q, overflow_d;
   logic [7:0]    mem_q [FIFO_DEPTH];

   logic       latch_rise, pulse_fall, joy_active, key_valid, push, pop;
   logic [7:0] joy_byte, pres_byte;

   assign latch_rise = latch_s2_q & ~latch_h_q;
   assign pulse_fall = ~pulse_s2_q & pulse_h_q;
   assign joy_active = |bus.joystick;
   // Famicom order is A,B,Select,Start,Up,Down,Left,Right from bit0, active-low.
   assign joy_byte   = ~{bus.joystick[0], bus.joystick[1], bus.joystick[2], bus.joystick[3],
                         bus.joystick[7], bus.joystick[6], bus.joystick[5], bus.joystick[4]};
   assign key_valid  = bus.key_strobe & (bus.key_ascii != 8'h00);
   assign push       = key_valid & (count_q != FULL_CNT);

   always_comb begin
      latch_s1_d = bus.famicom_latch;
      latch_s2_d = latch_s1_q;
      latch_h_d  = latch_s2_q;
      pulse_s1_d = bus.famicom_pulse;
      pulse_s2_d = pulse_s1_q;
      pulse_h_d  = pulse_s2_q;
   end

   // Scheduler only moves on frames the keyboard actually owns.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cur_d   = cur_q;
      pop     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!latch_rise && !joy_active && count_q != '0) begin
               pop     = 1'b1;
               cur_d   = mem_q[rd_ptr_q];
               cnt_d   = '0;
               state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (latch_rise && !joy_active) begin
               if (cnt_q == HOLD_LAST) begin
                  cnt_d   = '0;
                  state_d = ST_GAP;
               end else begin
                  cnt_d = cnt_q + NW'(1);
               end
            end
         end
         ST_GAP: begin
            if (latch_rise && !joy_active) begin
               if (cnt_q == GAP_LAST) begin
                  cnt_d   = '0;
                  state_d = ST_IDLE;
               end else begin
                  cnt_d = cnt_q + NW'(1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      if (joy_active)
         pres_byte = joy_byte;
      else if (state_q == ST_HOLD)
         pres_byte = ~cur_q;
      else
         pres_byte = 8'hFF;

      sr_d = sr_q;
      if (latch_rise)
         sr_d = pres_byte;
      else if (pulse_fall)
         sr_d = {1'b1, sr_q[7:1]};

      wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d    = count_q;
      if (push && !pop)
         count_d = count_q + CW'(1);
      else if (pop && !push)
         count_d = count_q - CW'(1);
      overflow_d = key_valid & ~push;
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         latch_s1_q <= 1'b0;
         latch_s2_q <= 1'b0;
         latch_h_q  <= 1'b0;
         pulse_s1_q <= 1'b0;
         pulse_s2_q <= 1'b0;
         pulse_h_q  <= 1'b0;
         sr_q       <= 8'hFF;
         cur_q      <= 8'h00;
         cnt_q      <= '0;
         state_q    <= ST_IDLE;
         count_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         overflow_q <= 1'b0;
      end else begin
         latch_s1_q <= latch_s1_d;
         latch_s2_q <= latch_s2_d;
         latch_h_q  <= latch_h_d;
         pulse_s1_q <= pulse_s1_d;
         pulse_s2_q <= pulse_s2_d;
         pulse_h_q  <= pulse_h_d;
         sr_q       <= sr_d;
         cur_q      <= cur_d;
         cnt_q      <= cnt_d;
         state_q    <= state_d;
         count_q    <= count_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         overflow_q <= overflow_d;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (push)
         mem_q[wr_ptr_q] <= bus.key_ascii;
   end

   assign bus.famicom_data = sr_q[0];
   assign bus.fifo_count   = count_q;
   assign bus.overflow     = overflow_q;
   assign bus.busy         = (state_q != ST_IDLE);
endmodule

// File: tb/tb_famicom_input_arbiter.sv
// Directed bench for famicom_input_arbiter: serial reads of joystick and
// keyboard bytes, FIFO overflow, joystick priority, load-vs-shift and reset.
module tb_famicom_input_arbiter;
   logic clk;
   logic reset;
   int   passed;
   int   total;

   famicom_input_arbiter_if bus ();

   famicom_input_arbiter dut (
      .clk_sys (clk),
      .reset   (reset),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
   endtask

   task automatic pulse_once();
      bus.famicom_pulse = 1'b1;
      tick(5);
      bus.famicom_pulse = 1'b0;
      tick(5);
   endtask

   // One full controller read: latch, sample bit0, then 7 shifts.
   task automatic read_byte(output logic [7:0] b);
      bus.famicom_latch = 1'b1;
      tick(5);
      b[0] = bus.famicom_data;
      bus.famicom_latch = 1'b0;
      tick(5);
      for (int i = 1; i < 8; i++) begin
         pulse_once();
         b[i] = bus.famicom_data;
      end
   endtask

   task automatic strobe(input logic [7:0] v);
      bus.key_strobe = 1'b1;
      bus.key_ascii  = v;
      tick(1);
      bus.key_strobe = 1'b0;
      bus.key_ascii  = 8'h00;
   endtask

   initial begin
      logic [7:0] b;
      logic [7:0] exp;
      passed = 0;
      total  = 0;
      reset  = 1'b1;
      bus.joystick      = 8'h00;
      bus.key_strobe    = 1'b0;
      bus.key_ascii     = 8'h00;
      bus.famicom_latch = 1'b0;
      bus.famicom_pulse = 1'b0;
      tick(3);
      reset = 1'b0;
      tick(1);

      check("rst_data", {7'd0, bus.famicom_data}, 8'h01);
      check("rst_busy", {7'd0, bus.busy}, 8'h00);
      check("rst_count", 8'(bus.fifo_count), 8'h00);
      check("rst_ovf", {7'd0, bus.overflow}, 8'h00);

      read_byte(b);
      check("idle_read", b, 8'hFF);
      check("idle_busy", {7'd0, bus.busy}, 8'h00);
      check("idle_count", 8'(bus.fifo_count), 8'h00);

      bus.joystick = 8'h10;
      read_byte(b);
      check("joy_A", b, 8'hFE);
      bus.joystick = 8'h88;
      read_byte(b);
      check("joy_start_up", b, 8'hE7);
      bus.joystick = 8'h01;
      read_byte(b);
      check("joy_right", b, 8'h7F);
      check("joy_right_bit7", {7'd0, bus.famicom_data}, 8'h00);
      pulse_once();
      check("extra_pulse", {7'd0, bus.famicom_data}, 8'h01);
      bus.joystick = 8'h00;

      strobe(8'h00);
      tick(1);
      check("nul_count", 8'(bus.fifo_count), 8'h00);
      check("nul_ovf", {7'd0, bus.overflow}, 8'h00);
      check("nul_busy", {7'd0, bus.busy}, 8'h00);

      strobe(8'h41);
      tick(2);
      check("keyA_busy", {7'd0, bus.busy}, 8'h01);
      check("keyA_count", 8'(bus.fifo_count), 8'h00);
      for (int r = 1; r <= 7; r++) begin
         read_byte(b);
         exp = (r <= 3) ? 8'hBE : 8'hFF;
         check($sformatf("keyA_r%0d", r), b, exp);
         if (r == 4) check("keyA_busy_r4", {7'd0, bus.busy}, 8'h01);
         if (r == 5) check("keyA_busy_r5", {7'd0, bus.busy}, 8'h00);
      end

      for (int k = 0; k < 5; k++) begin
         strobe(8'h31 + 8'(k));
      end
      check("q5_count", 8'(bus.fifo_count), 8'h04);
      check("q5_ovf", {7'd0, bus.overflow}, 8'h00);
      strobe(8'h36);
      check("q6_ovf", {7'd0, bus.overflow}, 8'h01);
      check("q6_count", 8'(bus.fifo_count), 8'h04);
      tick(1);
      check("q6_ovf_clear", {7'd0, bus.overflow}, 8'h00);
      for (int k = 0; k < 5; k++) begin
         for (int r = 1; r <= 5; r++) begin
            read_byte(b);
            exp = (r <= 3) ? ~(8'h31 + 8'(k)) : 8'hFF;
            check($sformatf("q_key%0d_r%0d", k, r), b, exp);
         end
         tick(2);
         check($sformatf("q_key%0d_count", k), 8'(bus.fifo_count), 8'(3 - k + ((k == 4) ? 1 : 0)));
         check($sformatf("q_key%0d_busy", k), {7'd0, bus.busy}, (k == 4) ? 8'h00 : 8'h01);
      end

      bus.joystick = 8'h01;
      strobe(8'h42);
      tick(2);
      check("jp_count_held", 8'(bus.fifo_count), 8'h01);
      for (int r = 1; r <= 4; r++) begin
         read_byte(b);
         check($sformatf("jp_joy_r%0d", r), b, 8'h7F);
      end
      bus.joystick = 8'h00;
      tick(2);
      check("jp_count_rel", 8'(bus.fifo_count), 8'h00);
      check("jp_busy_rel", {7'd0, bus.busy}, 8'h01);
      for (int r = 1; r <= 5; r++) begin
         read_byte(b);
         exp = (r <= 3) ? 8'hBD : 8'hFF;
         check($sformatf("jp_key_r%0d", r), b, exp);
      end
      check("jp_busy_end", {7'd0, bus.busy}, 8'h00);

      // Latch rise and pulse fall land in the same synchronized cycle.
      bus.joystick = 8'h10;
      bus.famicom_pulse = 1'b1;
      tick(5);
      bus.famicom_latch = 1'b1;
      bus.famicom_pulse = 1'b0;
      tick(5);
      b[0] = bus.famicom_data;
      check("lw_bit0", {7'd0, bus.famicom_data}, 8'h00);
      bus.famicom_latch = 1'b0;
      tick(5);
      for (int i = 1; i < 8; i++) begin
         pulse_once();
         b[i] = bus.famicom_data;
      end
      check("lw_byte", b, 8'hFE);
      bus.joystick = 8'h00;

      strobe(8'h43);
      tick(1);
      strobe(8'h44);
      tick(2);
      check("rh_count", 8'(bus.fifo_count), 8'h01);
      check("rh_busy", {7'd0, bus.busy}, 8'h01);
      read_byte(b);
      check("rh_first", b, 8'hBC);
      bus.famicom_latch = 1'b1;
      tick(5);
      check("rh_loaded_bit0", {7'd0, bus.famicom_data}, 8'h00);
      bus.famicom_latch = 1'b0;
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
      tick(1);
      check("rh_data", {7'd0, bus.famicom_data}, 8'h01);
      check("rh_count_rst", 8'(bus.fifo_count), 8'h00);
      check("rh_busy_rst", {7'd0, bus.busy}, 8'h00);
      read_byte(b);
      check("rh_after", b, 8'hFF);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
